// File: rtl/expr_eval.sv
// expr_eval: evaluates a one-character-per-cycle ASCII expression built from
// single-digit operands and the operators '+' and '*', with '*' binding
// tighter than '+'. All arithmetic is modulo 2^W.
//
// Ports:
//   clk_i     clock, state updates on the rising edge
//   clr_ni    asynchronous active-low clear of all state
//   en_i      character strobe, in_i is consumed only when en_i=1
//   in_i      ASCII character
//   ok_o      characters so far form a complete valid expression
//   err_o     sticky syntax error
//   ovf_o     sticky arithmetic wrap (multiply or committed add)
//   result_o  (sum + term) mod 2^W of the expression so far
module expr_eval #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic         en_i,
  input  logic [7:0]   in_i,
  output logic         ok_o,
  output logic         err_o,
  output logic         ovf_o,
  output logic [W-1:0] result_o
);

  typedef enum logic [1:0] {
    StExpectNum,
    StAfterNum,
    StError
  } st_e;

  st_e          st_q, st_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] term_q, term_d;
  logic         mul_q, mul_d;
  logic         ovf_q, ovf_d;

  // Character classification
  logic         is_digit;
  logic         is_plus;
  logic         is_star;
  logic [7:0]   digit_wide;
  logic [3:0]   digit;

  assign is_digit   = (in_i >= 8'h30) && (in_i <= 8'h39);
  assign is_plus    = (in_i == 8'h2b);
  assign is_star    = (in_i == 8'h2a);
  assign digit_wide = in_i - 8'h30;
  assign digit      = digit_wide[3:0];

  // Full-width product and sum so the wrap can be detected from the top bits
  logic [W+3:0] prod_full;
  logic [W:0]   sum_full;

  assign prod_full = {4'b0000, term_q} * {{W{1'b0}}, digit};
  assign sum_full  = {1'b0, sum_q} + {1'b0, term_q};

  always_comb begin
    st_d   = st_q;
    sum_d  = sum_q;
    term_d = term_q;
    mul_d  = mul_q;
    ovf_d  = ovf_q;
    if (en_i) begin
      unique case (st_q)
        StExpectNum: begin
          if (is_digit) begin
            if (mul_q) begin
              term_d = prod_full[W-1:0];
              if (prod_full[W+3:W] != 4'b0000) begin
                ovf_d = 1'b1;
              end
            end else begin
              term_d = {{(W-4){1'b0}}, digit};
            end
            mul_d = 1'b0;
            st_d  = StAfterNum;
          end else begin
            st_d = StError;
          end
        end
        StAfterNum: begin
          if (is_plus) begin
            sum_d  = sum_full[W-1:0];
            ovf_d  = ovf_q | sum_full[W];
            term_d = '0;
            mul_d  = 1'b0;
            st_d   = StExpectNum;
          end else if (is_star) begin
            mul_d = 1'b1;
            st_d  = StExpectNum;
          end else begin
            st_d = StError;
          end
        end
        default: begin
          // Error is absorbing: everything frozen until clear.
          st_d = StError;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      st_q   <= StExpectNum;
      sum_q  <= '0;
      term_q <= '0;
      mul_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      sum_q  <= sum_d;
      term_q <= term_d;
      mul_q  <= mul_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ok_o     = (st_q == StAfterNum);
  assign err_o    = (st_q == StError);
  assign ovf_o    = ovf_q;
  // Final add is not committed, so its carry never touches ovf.
  assign result_o = sum_q + term_q;

endmodule
